// File: rtl/stdadd_pipe.sv
// Pipelined WIDTH-bit adder/subtractor with carry-in, valid/ready on both sides.
// The carry chain is cut into STAGES slices of SW bits, one slice resolved per rank.
module stdadd_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF
);

    localparam int SW = WIDTH / STAGES;

    // Rank 0 holds captured operands; rank k+1 holds the result of slice k.
    // acc carries {unprocessed A bits, finished sum bits}; b keeps only unprocessed effective-B bits.
    logic             v_q   [STAGES+1];
    logic [WIDTH-1:0] acc_q [STAGES+1];
    logic [WIDTH-1:0] b_q   [STAGES+1];
    logic             c_q   [STAGES+1];
    logic             ovf_q;

    logic [WIDTH-1:0] acc_n [STAGES];
    logic [WIDTH-1:0] b_n   [STAGES];
    logic             c_n   [STAGES];
    logic             ovf_n;
    logic             advance;

    assign advance   = ~v_q[STAGES] | OUT_READY;
    assign IN_READY  = advance;
    assign OUT_VALID = v_q[STAGES];
    assign SUM       = acc_q[STAGES];
    assign COUT      = c_q[STAGES];
    assign OVF       = ovf_q;

    always_comb begin
        logic [SW:0] slice;
        slice = '0;
        for (int k = 0; k < STAGES; k++) begin
            slice = {1'b0, acc_q[k][k*SW +: SW]} + {1'b0, b_q[k][k*SW +: SW]}
                  + {{SW{1'b0}}, c_q[k]};
            acc_n[k]               = acc_q[k];
            acc_n[k][k*SW +: SW]   = slice[SW-1:0];
            b_n[k]                 = b_q[k];
            b_n[k][k*SW +: SW]     = '0;
            c_n[k]                 = slice[SW];
        end
        // Overflow: operands agree in sign but the result does not.
        ovf_n = (acc_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
             && (acc_n[STAGES-1][WIDTH-1] != acc_q[STAGES-1][WIDTH-1]);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            for (int k = 0; k <= STAGES; k++) begin
                v_q[k]   <= 1'b0;
                acc_q[k] <= '0;
                b_q[k]   <= '0;
                c_q[k]   <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            v_q[0] <= IN_VALID;
            if (IN_VALID) begin
                acc_q[0] <= A;
                b_q[0]   <= SUB ? ~B : B;
                c_q[0]   <= CIN;
            end
            // Data only moves with a valid token, so bubbles leave outputs untouched.
            for (int k = 0; k < STAGES; k++) begin
                v_q[k+1] <= v_q[k];
                if (v_q[k]) begin
                    acc_q[k+1] <= acc_n[k];
                    b_q[k+1]   <= b_n[k];
                    c_q[k+1]   <= c_n[k];
                end
            end
            if (v_q[STAGES-1]) ovf_q <= ovf_n;
        end
    end

endmodule

// File: tb/tb_stdadd_pipe.sv
// Bench for stdadd_pipe: directed scenarios on an 8/2 instance plus randomized
// handshake traffic on 8/2, 32/1, 32/4 and 16/8 against an arithmetic reference.
module tb_stdadd_pipe;

    logic        clk;
    logic        rst_n;
    logic [31:0] a    [4];
    logic [31:0] b    [4];
    logic        cin  [4];
    logic        sub  [4];
    logic        iv   [4];
    logic        ordy [4];
    logic        ir   [4];
    logic        ov   [4];
    logic        cout_x [4];
    logic        ovf_x  [4];
    logic [31:0] sum_x  [4];
    logic [7:0]  sum8;
    logic [31:0] sum32a;
    logic [31:0] sum32b;
    logic [15:0] sum16;

    logic [33:0] exp_q [4][64];
    int          rp [4];
    int          wp [4];
    int          checks;
    int          errors;
    int          cyc;
    int          pops0;
    int          first0;
    int          last0;
    logic [31:0] snap_sum;
    logic        snap_ov;

    assign sum_x[0] = {24'b0, sum8};
    assign sum_x[1] = sum32a;
    assign sum_x[2] = sum32b;
    assign sum_x[3] = {16'b0, sum16};

    stdadd_pipe #(.WIDTH(8), .STAGES(2)) dut8 (
        .CLK(clk), .RESET_N(rst_n), .IN_VALID(iv[0]), .IN_READY(ir[0]),
        .A(a[0][7:0]), .B(b[0][7:0]), .CIN(cin[0]), .SUB(sub[0]),
        .OUT_VALID(ov[0]), .OUT_READY(ordy[0]), .SUM(sum8), .COUT(cout_x[0]), .OVF(ovf_x[0]));

    stdadd_pipe #(.WIDTH(32), .STAGES(1)) dut32s1 (
        .CLK(clk), .RESET_N(rst_n), .IN_VALID(iv[1]), .IN_READY(ir[1]),
        .A(a[1]), .B(b[1]), .CIN(cin[1]), .SUB(sub[1]),
        .OUT_VALID(ov[1]), .OUT_READY(ordy[1]), .SUM(sum32a), .COUT(cout_x[1]), .OVF(ovf_x[1]));

    stdadd_pipe #(.WIDTH(32), .STAGES(4)) dut32s4 (
        .CLK(clk), .RESET_N(rst_n), .IN_VALID(iv[2]), .IN_READY(ir[2]),
        .A(a[2]), .B(b[2]), .CIN(cin[2]), .SUB(sub[2]),
        .OUT_VALID(ov[2]), .OUT_READY(ordy[2]), .SUM(sum32b), .COUT(cout_x[2]), .OVF(ovf_x[2]));

    stdadd_pipe #(.WIDTH(16), .STAGES(8)) dut16s8 (
        .CLK(clk), .RESET_N(rst_n), .IN_VALID(iv[3]), .IN_READY(ir[3]),
        .A(a[3][15:0]), .B(b[3][15:0]), .CIN(cin[3]), .SUB(sub[3]),
        .OUT_VALID(ov[3]), .OUT_READY(ordy[3]), .SUM(sum16), .COUT(cout_x[3]), .OVF(ovf_x[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int width_of(input int i);
        case (i)
            0:       return 8;
            3:       return 16;
            default: return 32;
        endcase
    endfunction

    // Returns {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [33:0] ref_add(input int w, input logic [31:0] a_in,
                                            input logic [31:0] b_in, input logic c, input logic s);
        longint m, half, av, bv, u, sa, sb, sv;
        logic   o, co;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        av   = longint'(a_in) & m;
        bv   = (s ? ~longint'(b_in) : longint'(b_in)) & m;
        u    = av + bv + longint'(c);
        co   = ((u >> w) & 1) != 0;
        sa   = (av >= half) ? av - 2 * half : av;
        sb   = (bv >= half) ? bv - 2 * half : bv;
        sv   = sa + sb + longint'(c);
        o    = (sv >= half) || (sv < -half);
        return {o, co, 32'(u & m)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rand_ops(input int i);
        a[i]   = $urandom();
        b[i]   = $urandom();
        cin[i] = 1'($urandom_range(0, 1));
        sub[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic set_op(input int i, input logic [31:0] av, input logic [31:0] bv,
                          input logic c, input logic s);
        a[i] = av; b[i] = bv; cin[i] = c; sub[i] = s; iv[i] = 1'b1;
    endtask

    // One clock: settle, score retiring results, record captured operands, advance.
    task automatic tick();
        logic was_rst;
        #1;
        was_rst = !rst_n;
        for (int i = 0; i < 4; i++) begin
            if (!was_rst && ov[i] && ordy[i]) begin
                if (rp[i] == wp[i]) begin
                    check($sformatf("spurious_result_dut%0d", i), 64'(ov[i]), 64'd0);
                end else begin
                    check($sformatf("result_dut%0d_op%0d", i, rp[i]),
                          64'({ovf_x[i], cout_x[i], sum_x[i]}), 64'(exp_q[i][rp[i] % 64]));
                    rp[i]++;
                    if (i == 0) begin
                        if (first0 < 0) first0 = cyc;
                        last0 = cyc;
                        pops0++;
                    end
                end
            end
            if (!was_rst && iv[i] && ir[i]) begin
                exp_q[i][wp[i] % 64] = ref_add(width_of(i), a[i], b[i], cin[i], sub[i]);
                wp[i]++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (was_rst) for (int i = 0; i < 4; i++) rp[i] = wp[i];
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; pops0 = 0; first0 = -1; last0 = -1;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rp[i] = 0; wp[i] = 0;
            a[i] = '0; b[i] = '0; cin[i] = 1'b0; sub[i] = 1'b0;
            iv[i] = 1'b0; ordy[i] = 1'b1;
        end
        set_op(0, 32'h33, 32'h44, 1'b1, 1'b0);

        // Reset held with IN_VALID high
        repeat (3) tick();
        check("reset_out_valid", 64'(ov[0]), 64'd0);
        check("reset_sum", 64'(sum_x[0]), 64'h00);
        check("reset_cout", 64'(cout_x[0]), 64'd0);
        check("reset_ovf", 64'(ovf_x[0]), 64'd0);
        check("reset_in_ready", 64'(ir[0]), 64'd1);
        for (int i = 1; i < 4; i++) check($sformatf("reset_out_valid_dut%0d", i), 64'(ov[i]), 64'd0);

        rst_n = 1'b1;
        iv[0] = 1'b0;
        repeat (4) begin
            tick();
            check("idle_after_reset", 64'(ov[0]), 64'd0);
        end

        // Cross-slice carry and signed overflow
        set_op(0, 32'hFF, 32'h01, 1'b0, 1'b0);
        tick();
        set_op(0, 32'h7F, 32'h01, 1'b0, 1'b0);
        tick();
        check("latency_not_early", 64'(ov[0]), 64'd0);
        iv[0] = 1'b0;
        tick();
        check("carry_valid", 64'(ov[0]), 64'd1);
        check("carry_sum", 64'(sum_x[0]), 64'h00);
        check("carry_cout", 64'(cout_x[0]), 64'd1);
        check("carry_ovf", 64'(ovf_x[0]), 64'd0);
        tick();
        check("ovf_valid", 64'(ov[0]), 64'd1);
        check("ovf_sum", 64'(sum_x[0]), 64'h80);
        check("ovf_cout", 64'(cout_x[0]), 64'd0);
        check("ovf_ovf", 64'(ovf_x[0]), 64'd1);
        tick();
        check("carry_drained", 64'(ov[0]), 64'd0);

        // Subtract with and without borrow-in
        set_op(0, 32'h05, 32'h07, 1'b1, 1'b1);
        tick();
        set_op(0, 32'h05, 32'h07, 1'b0, 1'b1);
        tick();
        iv[0] = 1'b0;
        tick();
        check("sub_sum", 64'(sum_x[0]), 64'hFE);
        check("sub_cout", 64'(cout_x[0]), 64'd0);
        check("sub_ovf", 64'(ovf_x[0]), 64'd0);
        tick();
        check("sbc_sum", 64'(sum_x[0]), 64'hFD);
        check("sbc_cout", 64'(cout_x[0]), 64'd0);
        tick();

        // Back-to-back throughput
        pops0 = 0; first0 = -1; last0 = -1;
        for (int n = 0; n < 10; n++) begin
            rand_ops(0);
            iv[0] = 1'b1;
            tick();
        end
        iv[0] = 1'b0;
        repeat (4) tick();
        check("b2b_count", 64'(pops0), 64'd10);
        check("b2b_contiguous", 64'(last0 - first0), 64'd9);

        // Backpressure: full pipe, consumer stalls 5 cycles while producer keeps offering
        for (int n = 0; n < 4; n++) begin
            rand_ops(0);
            iv[0] = 1'b1;
            tick();
        end
        ordy[0] = 1'b0;
        snap_sum = sum_x[0];
        snap_ov  = ov[0];
        check("stall_entry_valid", 64'(snap_ov), 64'd1);
        for (int n = 0; n < 5; n++) begin
            rand_ops(0);
            tick();
            check($sformatf("stall_in_ready_%0d", n), 64'(ir[0]), 64'd0);
            check($sformatf("stall_sum_frozen_%0d", n), 64'(sum_x[0]), 64'(snap_sum));
            check($sformatf("stall_valid_frozen_%0d", n), 64'(ov[0]), 64'(snap_ov));
        end
        ordy[0] = 1'b1;
        iv[0] = 1'b0;
        repeat (6) tick();
        check("stall_drain", 64'(rp[0]), 64'(wp[0]));

        // Reset with two operations in flight
        for (int n = 0; n < 2; n++) begin
            rand_ops(0);
            iv[0] = 1'b1;
            tick();
        end
        iv[0] = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midreset_valid", 64'(ov[0]), 64'd0);
        repeat (5) begin
            tick();
            check("midreset_no_stale", 64'(ov[0]), 64'd0);
        end

        // Randomized traffic with independent handshakes on every configuration
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 4; i++) begin
                rand_ops(i);
                iv[i]   = ($urandom_range(0, 9) < 7);
                ordy[i] = ($urandom_range(0, 9) < 7);
            end
            if (n == 0) begin
                set_op(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
                set_op(3, 32'h0000_FFFF, 32'h1, 1'b0, 1'b0);
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0;
            ordy[i] = 1'b1;
        end
        repeat (12) tick();
        for (int i = 0; i < 4; i++) check($sformatf("random_drain_dut%0d", i), 64'(rp[i]), 64'(wp[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
